// File: rtl/sbus_mem_seq_pkg.sv
// ---------------------------------------------------------------------------
// sbus_mem_seq_pkg
// Shared MBOX definitions for the SBUS memory-request sequencer:
//   sbus_seq_state_t : sequencer state encoding
//   mem_rq_t         : latched core request (rd, wr, word mask, address)
//   odd_par()        : odd parity bit over a request address
// ---------------------------------------------------------------------------
package sbus_mem_seq_pkg;

    // Widest physical address the request register can hold (PMA[0:35]).
    // Narrower buses zero-extend into it, which leaves parity unchanged.
    localparam int RQ_ADR_W = 36;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_DATA = 3'd2,
        NXM_FILL  = 3'd3,
        DONE      = 3'd4
    } sbus_seq_state_t;

    typedef struct packed {
        logic                rd;
        logic                wr;
        logic [3:0]          word_rq;
        logic [RQ_ADR_W-1:0] adr;
    } mem_rq_t;

    // Parity bit that makes the total count of ones (address + bit) odd.
    function automatic logic odd_par(input logic [RQ_ADR_W-1:0] a);
        return ~(^a);
    endfunction

endpackage

// File: rtl/sbus_mem_seq_nxm_timer.sv
// ---------------------------------------------------------------------------
// sbus_mem_seq_nxm_timer
// Saturating non-existent-memory timeout counter.
// Ports:
//   clk      in  clock
//   RESET_n  in  synchronous active-low reset (count -> 0)
//   clear    in  restart the count at 0 (wins over enable)
//   enable   in  count this cycle
//   expired  out count has reached NXM_TIMEOUT-1
// ---------------------------------------------------------------------------
module sbus_mem_seq_nxm_timer #(
    parameter int NXM_TIMEOUT = 64
) (
    input  logic clk,
    input  logic RESET_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            TW   = (NXM_TIMEOUT > 1) ? $clog2(NXM_TIMEOUT) : 1;
    localparam logic [TW-1:0] LAST = TW'(NXM_TIMEOUT - 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (!RESET_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            // Holding at LAST keeps the count saturated until cleared.
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/sbus_mem_seq.sv
// ---------------------------------------------------------------------------
// sbus_mem_seq
// Memory-request sequencer between MBOX control/error logic and the SBUS.
// Accepts one request per mem_start, holds SBUS start/request lines until
// ACKN, steers returned read words to the MB with word numbers, and
// fabricates zero words after a non-existent-memory timeout.
// Ports:
//   clk, RESET_n                  clock, synchronous active-low reset
//   mem_start, mem_rd_rq,
//   mem_wr_rq, word_rq, adr       core request (both rd+wr = read-pause-write)
//   nxm_clr                       clears nxm_flag and rq_overrun
//   sbus_ackn, sbus_data_valid,
//   sbus_adr_par_err              memory responses
//   sbus_start, sbus_rd_rq,
//   sbus_wr_rq, sbus_rq,
//   sbus_adr, sbus_adr_par        SBUS request lines (valid in START)
//   mem_busy                      not IDLE
//   ackn_pulse                    first ACKN of a request (same cycle)
//   data_valid, word_num,
//   nxm_data                      one delivered read word per pulse
//   nxm_flag, adr_par_err,
//   rq_overrun                    sticky status
//   done                          one-cycle completion pulse
// ---------------------------------------------------------------------------
module sbus_mem_seq
    import sbus_mem_seq_pkg::*;
#(
    parameter int NXM_TIMEOUT = 64,
    parameter int ADR_W       = 22
) (
    input  logic             clk,
    input  logic             RESET_n,
    input  logic             mem_start,
    input  logic             mem_rd_rq,
    input  logic             mem_wr_rq,
    input  logic [3:0]       word_rq,
    input  logic [ADR_W-1:0] adr,
    input  logic             nxm_clr,
    input  logic             sbus_ackn,
    input  logic             sbus_data_valid,
    input  logic             sbus_adr_par_err,
    output logic             sbus_start,
    output logic             sbus_rd_rq,
    output logic             sbus_wr_rq,
    output logic [3:0]       sbus_rq,
    output logic [ADR_W-1:0] sbus_adr,
    output logic             sbus_adr_par,
    output logic             mem_busy,
    output logic             ackn_pulse,
    output logic             data_valid,
    output logic [1:0]       word_num,
    output logic             nxm_data,
    output logic             nxm_flag,
    output logic             adr_par_err,
    output logic             rq_overrun,
    output logic             done
);

    sbus_seq_state_t state;
    mem_rq_t         rq;
    logic [3:0]      pending;

    logic            timer_clear;
    logic            timer_en;
    logic            timer_expired;

    logic [1:0]      pick_idx;
    logic [3:0]      pick_mask;
    logic            in_start;
    logic            accept;
    logic            deliver_bus;

    assign in_start    = (state == START);
    assign accept      = (state == IDLE) && mem_start;
    assign deliver_bus = (state == WAIT_DATA) && sbus_data_valid && (pending != 4'b0000);

    // The timer restarts on accept, on ACKN and on every word the memory
    // returns, so in WAIT_DATA it bounds the gap between data words.
    assign timer_clear = accept || (in_start && sbus_ackn) || deliver_bus;
    assign timer_en    = in_start || (state == WAIT_DATA);

    sbus_mem_seq_nxm_timer #(
        .NXM_TIMEOUT(NXM_TIMEOUT)
    ) u_nxm_timer (
        .clk    (clk),
        .RESET_n(RESET_n),
        .clear  (timer_clear),
        .enable (timer_en),
        .expired(timer_expired)
    );

    // Lowest-numbered pending word; scanning downward lets the lowest win.
    always_comb begin
        pick_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pending[i]) begin
                pick_idx = 2'(i);
            end
        end
        pick_mask = 4'b0001 << pick_idx;
    end

    // Request register is pure data: loaded on accept, never reset. Every
    // use of it is gated by state, so its contents are don't-care in IDLE.
    always_ff @(posedge clk) begin
        if (accept) begin
            rq.rd      <= mem_rd_rq;
            rq.wr      <= mem_wr_rq;
            rq.word_rq <= word_rq;
            rq.adr     <= RQ_ADR_W'(adr);
        end
    end

    // SBUS request lines are decoded from the registered state and the
    // request register, so they are glitch-free and zero outside START.
    assign sbus_start   = in_start;
    assign sbus_rd_rq   = in_start && rq.rd;
    assign sbus_wr_rq   = in_start && rq.wr;
    assign sbus_rq      = in_start ? rq.word_rq : 4'b0000;
    assign sbus_adr     = in_start ? rq.adr[ADR_W-1:0] : '0;
    assign sbus_adr_par = in_start && odd_par(rq.adr);
    assign mem_busy     = (state != IDLE);
    assign done         = (state == DONE);
    // Same-cycle acknowledge: START is left on ACKN, so this is the first one.
    assign ackn_pulse   = in_start && sbus_ackn;

    always_ff @(posedge clk) begin
        if (!RESET_n) begin
            state       <= IDLE;
            pending     <= 4'b0000;
            data_valid  <= 1'b0;
            word_num    <= 2'd0;
            nxm_data    <= 1'b0;
            nxm_flag    <= 1'b0;
            adr_par_err <= 1'b0;
            rq_overrun  <= 1'b0;
        end else begin
            data_valid <= 1'b0;

            // Clear first so that a set later in this block wins the cycle.
            if (nxm_clr) begin
                nxm_flag   <= 1'b0;
                rq_overrun <= 1'b0;
            end
            if (mem_start && (state != IDLE)) begin
                rq_overrun <= 1'b1;
            end
            if (sbus_adr_par_err && (in_start || (state == WAIT_DATA))) begin
                adr_par_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (mem_start) begin
                        // Writes never return data; read-pause-write counts as a read.
                        pending <= mem_rd_rq ? word_rq : 4'b0000;
                        state   <= START;
                    end
                end

                START: begin
                    if (sbus_ackn) begin
                        // ACKN outranks a simultaneous timeout.
                        state <= (pending != 4'b0000) ? WAIT_DATA : DONE;
                    end else if (timer_expired) begin
                        nxm_flag <= 1'b1;
                        state    <= rq.rd ? NXM_FILL : DONE;
                    end
                end

                WAIT_DATA: begin
                    if (pending == 4'b0000) begin
                        state <= DONE;
                    end else if (sbus_data_valid) begin
                        data_valid <= 1'b1;
                        word_num   <= pick_idx;
                        nxm_data   <= 1'b0;
                        pending    <= pending & ~pick_mask;
                    end else if (timer_expired) begin
                        nxm_flag <= 1'b1;
                        state    <= NXM_FILL;
                    end
                end

                NXM_FILL: begin
                    if (pending == 4'b0000) begin
                        state <= DONE;
                    end else begin
                        data_valid <= 1'b1;
                        word_num   <= pick_idx;
                        nxm_data   <= 1'b1;
                        pending    <= pending & ~pick_mask;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
